uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Two-requester packet arbiter in front of a shared DMA send channel.
//   Requester 0 (adc) and requester 1 (ctrl) present byte packets with a
//   length hint and a last flag. A round-robin pick happens in IDLE, one
//   packet at a time. Packets that stall mid-stream are closed with a pad beat.
// Ports
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_adc_* / o_adc_ready        : requester 0 packet stream
//   i_ctrl_* / o_ctrl_ready      : requester 1 packet stream
//   o_dma_t* / i_dma_tready      : shared DMA send channel
//   o_grant                      : one-hot owner (01 adc, 10 ctrl, 00 none)
//   o_timeout_pulse              : one cycle, first cycle of the pad beat
//   o_len_err_pulse              : one cycle, the cycle after a last beat whose
//                                  beat count disagreed with the latched length
module uart_tx_arbiter #(
    parameter int         P_TIMEOUT  = 5000,
    parameter logic [7:0] P_PAD_BYTE = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_adc_data,
    input  logic [7:0] i_adc_len,
    input  logic       i_adc_last,
    input  logic       i_adc_valid,
    output logic       o_adc_ready,
    input  logic [7:0] i_ctrl_data,
    input  logic [7:0] i_ctrl_len,
    input  logic       i_ctrl_last,
    input  logic       i_ctrl_valid,
    output logic       o_ctrl_ready,
    output logic [7:0] o_dma_tdata,
    output logic       o_dma_tlast,
    output logic       o_dma_tvalid,
    input  logic       i_dma_tready,
    output logic [1:0] o_grant,
    output logic       o_timeout_pulse,
    output logic       o_len_err_pulse
);
    localparam int            TW      = $clog2(P_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(P_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, XFER_ADC, XFER_CTRL, PAD} state_t;

    state_t        state_q, state_d;
    logic          last_ctrl_q, last_ctrl_d;    // 1: ctrl was granted last
    logic          owner_ctrl_q, owner_ctrl_d;  // owner of the current packet
    logic [8:0]    beat_q, beat_d;
    logic [8:0]    len_q, len_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          to_pulse_q, to_pulse_d;
    logic          len_err_q, len_err_d;

    logic          in_xfer, sel_ctrl, req_valid, req_last, beat;
    logic [7:0]    req_data, req_len;
    logic [8:0]    beat_inc, len_in, len_ref;

    assign o_timeout_pulse = to_pulse_q;
    assign o_len_err_pulse = len_err_q;

    always_comb begin
        in_xfer   = (state_q == XFER_ADC) || (state_q == XFER_CTRL);
        sel_ctrl  = (state_q == XFER_CTRL);
        req_valid = sel_ctrl ? i_ctrl_valid : i_adc_valid;
        req_last  = sel_ctrl ? i_ctrl_last  : i_adc_last;
        req_data  = sel_ctrl ? i_ctrl_data  : i_adc_data;
        req_len   = sel_ctrl ? i_ctrl_len   : i_adc_len;
        beat      = in_xfer && req_valid && i_dma_tready;
        // Saturating count: a runaway packet can never alias to a legal length.
        beat_inc  = (beat_q == 9'd511) ? beat_q : beat_q + 9'd1;
        len_in    = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
        // On the first beat the length has not been latched yet; compare
        // against the live input so one-beat packets are checked too.
        len_ref   = (beat_q == 9'd0) ? len_in : len_q;

        state_d      = state_q;
        last_ctrl_d  = last_ctrl_q;
        owner_ctrl_d = owner_ctrl_q;
        beat_d       = beat_q;
        len_d        = len_q;
        idle_d       = idle_q;
        to_pulse_d   = 1'b0;
        len_err_d    = 1'b0;

        o_dma_tdata  = 8'h00;
        o_dma_tlast  = 1'b0;
        o_dma_tvalid = 1'b0;
        o_adc_ready  = 1'b0;
        o_ctrl_ready = 1'b0;
        o_grant      = 2'b00;

        case (state_q)
            IDLE: begin
                // Counters are cleared every idle cycle, so any XFER starts clean.
                beat_d = '0;
                idle_d = '0;
                if (i_ctrl_valid && (!i_adc_valid || !last_ctrl_q)) begin
                    state_d      = XFER_CTRL;
                    owner_ctrl_d = 1'b1;
                end else if (i_adc_valid) begin
                    state_d      = XFER_ADC;
                    owner_ctrl_d = 1'b0;
                end
            end
            XFER_ADC, XFER_CTRL: begin
                o_dma_tdata  = req_data;
                o_dma_tlast  = req_last;
                o_dma_tvalid = req_valid;
                o_adc_ready  = !sel_ctrl && i_dma_tready;
                o_ctrl_ready = sel_ctrl && i_dma_tready;
                o_grant      = sel_ctrl ? 2'b10 : 2'b01;
                if (beat) begin
                    idle_d = '0;
                    beat_d = beat_inc;
                    if (beat_q == 9'd0) len_d = len_in;
                    if (req_last) begin
                        state_d     = IDLE;
                        last_ctrl_d = sel_ctrl;
                        len_err_d   = (beat_inc != len_ref);
                    end
                end else if (!req_valid) begin
                    // Only requester silence counts; DMA backpressure does not.
                    if (idle_q >= TO_LAST) begin
                        state_d    = PAD;
                        to_pulse_d = 1'b1;
                    end else begin
                        idle_d = idle_q + TW'(1);
                    end
                end
            end
            PAD: begin
                o_dma_tdata  = P_PAD_BYTE;
                o_dma_tlast  = 1'b1;
                o_dma_tvalid = 1'b1;
                o_grant      = owner_ctrl_q ? 2'b10 : 2'b01;
                if (i_dma_tready) begin
                    state_d     = IDLE;
                    last_ctrl_d = owner_ctrl_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            last_ctrl_q  <= 1'b0;
            owner_ctrl_q <= 1'b0;
            beat_q       <= '0;
            len_q        <= '0;
            idle_q       <= '0;
            to_pulse_q   <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_ctrl_q  <= last_ctrl_d;
            owner_ctrl_q <= owner_ctrl_d;
            beat_q       <= beat_d;
            len_q        <= len_d;
            idle_q       <= idle_d;
            to_pulse_q   <= to_pulse_d;
            len_err_q    <= len_err_d;
        end
    end
endmodule
